// File: rtl/tp_mul_su_pipe_if.sv
// Handshake bundle for tp_mul_su_pipe: operand/tag input stream and result output stream.
interface tp_mul_su_pipe_if #(
    parameter int A_W   = 16,
    parameter int B_W   = 11,
    parameter int P_W   = 26,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [P_W-1:0]   out_p;
    logic [TAG_W-1:0] out_tag;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag, out_ovf
    );
endinterface

// File: rtl/tp_mul_su_pipe.sv
// Pipelined signed x unsigned multiplier with shift, narrowing and overflow flag.
// Define TP_MUL_SU_PIPE_SAT_EN to saturate out_p on overflow instead of wrapping.
module tp_mul_su_pipe #(
    parameter int A_W    = 16,
    parameter int B_W    = 11,
    parameter int P_W    = 26,
    parameter int SHIFT  = 0,
    parameter int STAGES = 3,
    parameter int TAG_W  = 8
) (
    input  logic            ap_clk,
    input  logic            ap_rst,
    tp_mul_su_pipe_if.slave bus
);
    localparam int F_W = A_W + B_W + 1;

    logic                    adv_s;
    logic signed [F_W-1:0]   a_ext_s;
    logic signed [F_W-1:0]   b_ext_s;
    logic signed [F_W-1:0]   prod_s;
    logic signed [F_W-1:0]   nar_src_s;
    logic signed [F_W-1:0]   shf_s;
    logic [F_W-P_W:0]        hi_s;
    logic [P_W-1:0]          nar_p_s;
    logic                    nar_ovf_s;

    logic [STAGES-1:0]       vld_r;
    logic [TAG_W-1:0]        tag_r [STAGES];
    logic [P_W-1:0]          p_r;
    logic                    ovf_r;

    assign adv_s        = !vld_r[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv_s || ap_rst;

    // Full-width signed product; b is zero-extended so the product is exact.
    always_comb begin
        a_ext_s = F_W'($signed(bus.in_a));
        b_ext_s = $signed(F_W'(bus.in_b));
        prod_s  = a_ext_s * b_ext_s;
    end

    generate
        if (STAGES == 1) begin : g_one
            assign nar_src_s = prod_s;
        end else begin : g_multi
            logic signed [F_W-1:0] prod_r [STAGES-1];

            // Product pipeline feeding the final narrowing stage.
            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    for (int i = 0; i < STAGES - 1; i++) begin
                        prod_r[i] <= '0;
                    end
                end else if (adv_s) begin
                    prod_r[0] <= prod_s;
                    for (int i = 1; i < STAGES - 1; i++) begin
                        prod_r[i] <= prod_r[i-1];
                    end
                end
            end

            assign nar_src_s = prod_r[STAGES-2];
        end
    endgenerate

    // Shift and narrow; overflow when the discarded high bits are not a sign extension.
    always_comb begin
        shf_s     = nar_src_s >>> SHIFT;
        hi_s      = shf_s[F_W-1:P_W-1];
        nar_ovf_s = !((&hi_s) || !(|hi_s));
`ifdef TP_MUL_SU_PIPE_SAT_EN
        if (nar_ovf_s) begin
            if (shf_s[F_W-1]) begin
                nar_p_s = {1'b1, {(P_W-1){1'b0}}};
            end else begin
                nar_p_s = {1'b0, {(P_W-1){1'b1}}};
            end
        end else begin
            nar_p_s = shf_s[P_W-1:0];
        end
`else
        nar_p_s = shf_s[P_W-1:0];
`endif
    end

    // Valid and tag shift register; reset discards every in-flight beat.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld_r <= '0;
            for (int i = 0; i < STAGES; i++) begin
                tag_r[i] <= '0;
            end
        end else if (adv_s) begin
            vld_r[0] <= bus.in_valid;
            tag_r[0] <= bus.in_tag;
            for (int i = 1; i < STAGES; i++) begin
                vld_r[i] <= vld_r[i-1];
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Final result register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            p_r   <= '0;
            ovf_r <= 1'b0;
        end else if (adv_s) begin
            p_r   <= nar_p_s;
            ovf_r <= nar_ovf_s;
        end
    end

    assign bus.out_valid = vld_r[STAGES-1];
    assign bus.out_p     = p_r;
    assign bus.out_tag   = tag_r[STAGES-1];
    assign bus.out_ovf   = ovf_r;
endmodule

// File: doc/tp_mul_su_pipe.md
TP_MUL_SU_PIPE -- requirements
Module: tp_mul_su_pipe

Interface
REQ-001 SHALL have parameter A_W, default 16, width of the signed multiplicand.
REQ-002 SHALL have parameter B_W, default 11, width of the unsigned multiplier.
REQ-003 SHALL have parameter P_W, default 26, result width; legal range 2..A_W+B_W.
REQ-004 SHALL have parameter SHIFT, default 0, arithmetic right shift applied to the full product before narrowing; legal range 0..A_W+B_W-2.
REQ-005 SHALL have parameter STAGES, default 3, pipeline depth; legal range 1..6.
REQ-006 SHALL have parameter TAG_W, default 8, width of the sideband tag carried alongside the data.
REQ-007 ap_clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 ap_rst  in  1  synchronous, active-high reset.
REQ-009 in_valid  in  1  input beat present.
REQ-010 in_ready  out  1  block accepts a beat this cycle.
REQ-011 in_a  in  A_W  signed two's-complement operand.
REQ-012 in_b  in  B_W  unsigned operand.
REQ-013 in_tag  in  TAG_W  opaque sideband.
REQ-014 out_valid  out  1  result beat present.
REQ-015 out_ready  in  1  downstream accepts the result.
REQ-016 out_p  out  P_W  signed result.
REQ-017 out_tag  out  TAG_W  tag of the same beat as out_p.
REQ-018 out_ovf  out  1  narrowing of this beat lost significant bits.

Function
REQ-019 SHALL form full product F = in_a (signed) x {0,in_b}, width A_W+B_W+1 and exact for all inputs, including in_a = -2^(A_W-1) with in_b = 2^B_W-1.
REQ-020 SHALL compute S = F >>> SHIFT (arithmetic, sign-filling).
REQ-021 out_ovf SHALL be 1 iff S is outside [-2^(P_W-1), 2^(P_W-1)-1].
REQ-022 Without the macro of REQ-032, out_p SHALL be the low P_W bits of S (wrap).
REQ-023 Pipeline advance enable SHALL be adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally, and SHALL NOT depend on in_valid.
REQ-024 A beat is accepted when in_valid && in_ready; when adv=1, every stage register SHALL shift by one stage, and a bubble (valid=0) SHALL enter stage 1 if no beat is accepted.
REQ-025 When adv=0, all stage registers SHALL hold, and out_p/out_tag/out_ovf SHALL remain stable while out_valid=1.
REQ-026 With out_ready held at 1, a beat accepted in cycle n SHALL appear on out_valid/out_p in cycle n+STAGES; the block SHALL sustain one beat per cycle.
REQ-027 Beats SHALL exit in acceptance order; none SHALL be dropped or duplicated under any stall pattern.
REQ-028 Simultaneous output consumption and input acceptance in the same cycle SHALL be legal and lose no data.
REQ-029 Multiplication SHALL be registered in stage 1; shift/narrowing/saturation SHALL occupy the final stage when STAGES>=2; with STAGES=1 all logic precedes the single register.

Reset
REQ-030 On ap_rst=1 at a clock edge, all stage valid bits SHALL clear, and out_p, out_tag and out_ovf SHALL become 0 on the following cycle.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight beats; in_ready SHALL be 1 while ap_rst=1, but beats presented during reset SHALL NOT be accepted.

Configuration
REQ-032 Macro TP_MUL_SU_PIPE_SAT_EN: when defined, out_p SHALL saturate to 2^(P_W-1)-1 (S positive) or -2^(P_W-1) (S negative) whenever out_ovf=1, and SHALL equal S otherwise.
REQ-033 Without the macro, wrap per REQ-022 SHALL apply; out_ovf SHALL be produced in both builds.

Verification
REQ-034 Defaults, out_ready=1: accept in_a=-3, in_b=5, in_tag=0x2A at cycle 0 -> cycle 3 out_valid=1, out_p=-15, out_tag=0x2A, out_ovf=0.
REQ-035 Defaults, P_W=20: in_a=-32768, in_b=2047 -> S=-67076096, out_ovf=1; wrap build out_p = low 20 bits of S; SAT build out_p=-524288.
REQ-036 Stream of 10 beats, out_ready toggling 1,0,0,1,... -> all 10 outputs in order with correct values; out_p stable during every stall.
REQ-037 SHIFT=4: in_a=-17, in_b=1 -> out_p=-2 (arithmetic floor).
REQ-038 Pipeline full with out_ready=0, then ap_rst pulse -> out_valid=0 the following cycle, out_p=0, no stale beat emitted afterwards.
REQ-039 STAGES=1, out_ready=1, continuous input -> output one cycle after each input, in_ready held at 1.
